// File: rtl/simmem_wresp_release_bank.sv
// simmem_wresp_release_bank
//
// Write-response bank placed after the delay calculator. Every write address
// forwarded to the real memory reserves a slot, and the slot index is handed
// to the delay calculator as the write IID. Responses from the real memory
// are stored in the reserved slots in per-ID arrival order. A stored response
// is released into a single output register only when:
//   - the delay calculator enables it, and
//   - it is the oldest entry of its AXI ID list.
// Each release is confirmed back with a one-hot slot flag.
//
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   rsv_valid_i/ready_o      reservation handshake; rsv_id_i = AXI ID,
//                            rsv_iid_o = lowest free slot (the allocated IID)
//   in_valid_i/ready_o       response from the real memory (in_id_i, in_resp_i)
//   release_en_i             multi-hot release enables from the delay calculator
//   released_addr_onehot_o   slot popped into the output register this cycle
//   out_valid_o/ready_i      released response (out_id_o, out_resp_o)
//   occupancy_o              only with SIMMEM_WRESP_BANK_STATS_EN defined:
//                            non-free slots plus a valid output register
module simmem_wresp_release_bank #(
  parameter int unsigned Capacity  = 8,
  parameter int unsigned IdWidth   = 2,
  parameter int unsigned RespWidth = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          rsv_valid_i,
  output logic                          rsv_ready_o,
  input  logic [IdWidth-1:0]            rsv_id_i,
  output logic [$clog2(Capacity)-1:0]   rsv_iid_o,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [IdWidth-1:0]            in_id_i,
  input  logic [RespWidth-1:0]          in_resp_i,
  input  logic [Capacity-1:0]           release_en_i,
  output logic [Capacity-1:0]           released_addr_onehot_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [IdWidth-1:0]            out_id_o,
  output logic [RespWidth-1:0]          out_resp_o
`ifdef SIMMEM_WRESP_BANK_STATS_EN
  ,
  output logic [$clog2(Capacity):0]     occupancy_o
`endif
);

  localparam int unsigned IidWidth = $clog2(Capacity);
  localparam int unsigned NumIds   = 2 ** IdWidth;

  typedef logic [IidWidth-1:0]  iid_t;
  typedef logic [IdWidth-1:0]   id_t;
  typedef logic [RespWidth-1:0] resp_t;
  typedef logic [IidWidth:0]    cnt_t;

  typedef enum logic [1:0] {
    SLOT_FREE,
    SLOT_RESERVED,
    SLOT_STORED
  } slot_state_e;

  // Per-slot storage
  slot_state_e slot_state_q [Capacity];
  slot_state_e slot_state_d [Capacity];
  id_t         slot_id_q    [Capacity];
  id_t         slot_id_d    [Capacity];
  resp_t       slot_resp_q  [Capacity];
  resp_t       slot_resp_d  [Capacity];
  iid_t        slot_next_q  [Capacity];
  iid_t        slot_next_d  [Capacity];

  // Per-ID linked lists
  iid_t              head_q     [NumIds];
  iid_t              head_d     [NumIds];
  iid_t              tail_q     [NumIds];
  iid_t              tail_d     [NumIds];
  iid_t              fill_ptr_q [NumIds];
  iid_t              fill_ptr_d [NumIds];
  cnt_t              unfilled_q [NumIds];
  cnt_t              unfilled_d [NumIds];
  logic [NumIds-1:0] nonempty_q;
  logic [NumIds-1:0] nonempty_d;

  // Output register
  logic  out_valid_q, out_valid_d;
  id_t   out_id_q,    out_id_d;
  resp_t out_resp_q,  out_resp_d;

  logic                rsv_hs, in_hs, out_hs;
  logic                out_load, pop;
  iid_t                pop_idx, fill_slot;
  id_t                 pop_id;
  logic [Capacity-1:0] eligible;
  logic                free_found, pop_found;
  logic                list_empty_after;

  // Reservation and fill handshakes
  always_comb begin
    rsv_iid_o  = '0;
    free_found = 1'b0;
    for (int unsigned i = 0; i < Capacity; i++) begin
      if (slot_state_q[i] == SLOT_FREE && !free_found) begin
        free_found = 1'b1;
        rsv_iid_o  = iid_t'(i);
      end
    end
    rsv_ready_o = free_found;
    rsv_hs      = rsv_valid_i && rsv_ready_o;
    in_ready_o  = unfilled_q[in_id_i] != '0;
    in_hs       = in_valid_i && in_ready_o;
    fill_slot   = fill_ptr_q[in_id_i];
  end

  // Release selection: stored, enabled and oldest of its ID
  always_comb begin
    eligible  = '0;
    pop_idx   = '0;
    pop_found = 1'b0;
    for (int unsigned i = 0; i < Capacity; i++) begin
      eligible[i] = slot_state_q[i] == SLOT_STORED && release_en_i[i] &&
                    nonempty_q[slot_id_q[i]] &&
                    head_q[slot_id_q[i]] == iid_t'(i);
      if (eligible[i] && !pop_found) begin
        pop_found = 1'b1;
        pop_idx   = iid_t'(i);
      end
    end
    out_hs   = out_valid_q && out_ready_i;
    out_load = !out_valid_q || out_ready_i;
    pop      = out_load && pop_found;
    pop_id   = slot_id_q[pop_idx];
    released_addr_onehot_o = '0;
    if (pop) begin
      released_addr_onehot_o[pop_idx] = 1'b1;
    end
  end

  // Next-state. Ordering matters: pop and fill are applied first so that a
  // same-cycle reservation on the same ID sees the list and unfilled count
  // as they will be after those updates.
  always_comb begin
    slot_state_d     = slot_state_q;
    slot_id_d        = slot_id_q;
    slot_resp_d      = slot_resp_q;
    slot_next_d      = slot_next_q;
    head_d           = head_q;
    tail_d           = tail_q;
    fill_ptr_d       = fill_ptr_q;
    unfilled_d       = unfilled_q;
    nonempty_d       = nonempty_q;
    out_valid_d      = out_valid_q;
    out_id_d         = out_id_q;
    out_resp_d       = out_resp_q;
    list_empty_after = 1'b0;

    if (out_load) begin
      out_valid_d = pop;
    end
    if (pop) begin
      out_id_d              = pop_id;
      out_resp_d            = slot_resp_q[pop_idx];
      slot_state_d[pop_idx] = SLOT_FREE;
      if (tail_q[pop_id] == pop_idx) begin
        nonempty_d[pop_id] = 1'b0;
      end else begin
        head_d[pop_id] = slot_next_q[pop_idx];
      end
    end

    if (in_hs) begin
      slot_state_d[fill_slot] = SLOT_STORED;
      slot_resp_d[fill_slot]  = in_resp_i;
      fill_ptr_d[in_id_i]     = slot_next_q[fill_slot];
      unfilled_d[in_id_i]     = unfilled_q[in_id_i] - cnt_t'(1);
    end

    if (rsv_hs) begin
      slot_state_d[rsv_iid_o] = SLOT_RESERVED;
      slot_id_d[rsv_iid_o]    = rsv_id_i;
      list_empty_after        = !nonempty_d[rsv_id_i];
      if (list_empty_after) begin
        head_d[rsv_id_i]     = rsv_iid_o;
        nonempty_d[rsv_id_i] = 1'b1;
      end else begin
        slot_next_d[tail_q[rsv_id_i]] = rsv_iid_o;
      end
      tail_d[rsv_id_i] = rsv_iid_o;
      // No unfilled slot left for this ID after any fill: point at the new one
      if (unfilled_d[rsv_id_i] == '0) begin
        fill_ptr_d[rsv_id_i] = rsv_iid_o;
      end
      unfilled_d[rsv_id_i] = unfilled_d[rsv_id_i] + cnt_t'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < Capacity; i++) begin
        slot_state_q[i] <= SLOT_FREE;
        slot_id_q[i]    <= '0;
        slot_resp_q[i]  <= '0;
        slot_next_q[i]  <= '0;
      end
      for (int unsigned j = 0; j < NumIds; j++) begin
        head_q[j]     <= '0;
        tail_q[j]     <= '0;
        fill_ptr_q[j] <= '0;
        unfilled_q[j] <= '0;
      end
      nonempty_q  <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_resp_q  <= '0;
    end else begin
      slot_state_q <= slot_state_d;
      slot_id_q    <= slot_id_d;
      slot_resp_q  <= slot_resp_d;
      slot_next_q  <= slot_next_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      fill_ptr_q   <= fill_ptr_d;
      unfilled_q   <= unfilled_d;
      nonempty_q   <= nonempty_d;
      out_valid_q  <= out_valid_d;
      out_id_q     <= out_id_d;
      out_resp_q   <= out_resp_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_id_o    = out_id_q;
  assign out_resp_o  = out_resp_q;

`ifdef SIMMEM_WRESP_BANK_STATS_EN
  cnt_t occupancy_q, occupancy_d;

  // A pop only moves an entry from a slot into the output register, so it
  // leaves the count unchanged; only reservations and output handshakes move it.
  always_comb begin
    occupancy_d = occupancy_q + cnt_t'(rsv_hs) - cnt_t'(out_hs);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occupancy_q <= '0;
    end else begin
      occupancy_q <= occupancy_d;
    end
  end

  assign occupancy_o = occupancy_q;
`endif

endmodule

// File: tb/tb_simmem_wresp_release_bank.sv
module tb_simmem_wresp_release_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       rsv_valid;
  logic       rsv_ready;
  logic [1:0] rsv_id;
  logic [2:0] rsv_iid;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_id;
  logic [1:0] in_resp;
  logic [7:0] release_en;
  logic [7:0] onehot;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_id;
  logic [1:0] out_resp;
`ifdef SIMMEM_WRESP_BANK_STATS_EN
  logic [3:0] occupancy;
`endif

  int total = 0;
  int bad   = 0;

  simmem_wresp_release_bank #(
    .Capacity (8),
    .IdWidth  (2),
    .RespWidth(2)
  ) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .rsv_valid_i           (rsv_valid),
    .rsv_ready_o           (rsv_ready),
    .rsv_id_i              (rsv_id),
    .rsv_iid_o             (rsv_iid),
    .in_valid_i            (in_valid),
    .in_ready_o            (in_ready),
    .in_id_i               (in_id),
    .in_resp_i             (in_resp),
    .release_en_i          (release_en),
    .released_addr_onehot_o(onehot),
    .out_valid_o           (out_valid),
    .out_ready_i           (out_ready),
    .out_id_o              (out_id),
    .out_resp_o            (out_resp)
`ifdef SIMMEM_WRESP_BANK_STATS_EN
    ,
    .occupancy_o           (occupancy)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; checks happen 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    rsv_valid  = 1'b0;
    rsv_id     = '0;
    in_valid   = 1'b0;
    in_id      = '0;
    in_resp    = '0;
    release_en = '0;
    out_ready  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    #2;
    // Reset state
    chk("rst_rsv_ready", rsv_ready, 1);
    chk("rst_rsv_iid",   rsv_iid,   0);
    chk("rst_in_ready",  in_ready,  0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_onehot",    onehot,    0);
    chk("rst_out_id",    out_id,    0);
    chk("rst_out_resp",  out_resp,  0);
`ifdef SIMMEM_WRESP_BANK_STATS_EN
    chk("rst_occupancy", occupancy, 0);
`endif
    tick();
    rst = 1'b0;

    // Single reservation, fill and release
    rsv_valid = 1'b1; rsv_id = 2'd1;
    settle();
    chk("t1_iid0", rsv_iid, 0);
    tick();
    rsv_valid = 1'b0;
    in_valid = 1'b1; in_id = 2'd1; in_resp = 2'b10;
    release_en = 8'h01; out_ready = 1'b1;
    settle();
    chk("t1_in_ready", in_ready, 1);
    chk("t1_onehot_before_fill", onehot, 0);
    tick();
    in_valid = 1'b0;
    settle();
    chk("t1_onehot_pop", onehot, 8'h01);
    chk("t1_no_bypass", out_valid, 0);
    chk("t1_iid_busy", rsv_iid, 1);
    tick();
    settle();
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_id", out_id, 1);
    chk("t1_out_resp", out_resp, 2);
    chk("t1_onehot_single", onehot, 0);
    chk("t1_slot_freed", rsv_iid, 0);
    tick();
    settle();
    chk("t1_drained", out_valid, 0);
    idle_inputs();

    // Same-ID ordering: slots 0,1,2 with ID 0
    do_reset();
    rsv_valid = 1'b1; rsv_id = 2'd0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t2_rsv_iid", rsv_iid, i);
      tick();
    end
    rsv_valid = 1'b0;
    in_valid = 1'b1; in_id = 2'd0;
    for (int i = 0; i < 3; i++) begin
      in_resp = 2'(i + 1);
      settle();
      chk("t2_in_ready", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    settle();
    chk("t2_in_ready_done", in_ready, 0);
    release_en = 8'h04; out_ready = 1'b1;
    settle();
    chk("t2_nonhead_onehot", onehot, 0);
    tick();
    settle();
    chk("t2_nonhead_out", out_valid, 0);
    release_en = 8'h07;
    settle();
    chk("t2_pop0", onehot, 8'h01);
    tick();
    settle();
    chk("t2_out0_valid", out_valid, 1);
    chk("t2_out0_resp", out_resp, 1);
    chk("t2_out0_id", out_id, 0);
    chk("t2_pop1", onehot, 8'h02);
    tick();
    settle();
    chk("t2_out1_resp", out_resp, 2);
    chk("t2_pop2", onehot, 8'h04);
    tick();
    settle();
    chk("t2_out2_valid", out_valid, 1);
    chk("t2_out2_resp", out_resp, 3);
    chk("t2_no_more_pop", onehot, 0);
    tick();
    settle();
    chk("t2_drained", out_valid, 0);
    idle_inputs();

    // Full bank
    do_reset();
    rsv_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rsv_id = 2'(i);
      settle();
      chk("t3_rsv_ready", rsv_ready, 1);
      chk("t3_rsv_iid", rsv_iid, i);
      tick();
    end
    rsv_id = 2'd0;
    settle();
    chk("t3_full", rsv_ready, 0);
    tick();
    settle();
    chk("t3_still_full", rsv_ready, 0);
    rsv_valid = 1'b0;
    // Slot 3 holds ID 3 and is the head of that list
    in_valid = 1'b1; in_id = 2'd3; in_resp = 2'b01;
    settle();
    chk("t3_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    release_en = 8'h08;
    settle();
    chk("t3_pop3", onehot, 8'h08);
    chk("t3_free_registered", rsv_ready, 0);
    tick();
    release_en = 8'h00;
    settle();
    chk("t3_rsv_ready_back", rsv_ready, 1);
    chk("t3_rsv_iid3", rsv_iid, 3);
    chk("t3_out_id", out_id, 3);
    chk("t3_out_resp", out_resp, 1);
`ifdef SIMMEM_WRESP_BANK_STATS_EN
    chk("t3_occupancy", occupancy, 8);
`endif

    // Unexpected response stalls without side effects
    do_reset();
    rsv_valid = 1'b1; rsv_id = 2'd1;
    tick();
    rsv_valid = 1'b0;
    in_valid = 1'b1; in_id = 2'd2; in_resp = 2'b11;
    release_en = 8'hff; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("t4_in_ready_low", in_ready, 0);
      chk("t4_rsv_iid", rsv_iid, 1);
      chk("t4_out_valid", out_valid, 0);
      tick();
    end
    in_id = 2'd1;
    settle();
    chk("t4_id1_ready", in_ready, 1);
    idle_inputs();

    // Back-pressure on the output register
    do_reset();
    rsv_valid = 1'b1; rsv_id = 2'd0;
    tick();
    rsv_id = 2'd1;
    tick();
    rsv_valid = 1'b0;
    release_en = 8'h03; out_ready = 1'b0;
    in_valid = 1'b1; in_id = 2'd0; in_resp = 2'b01;
    tick();
    in_id = 2'd1; in_resp = 2'b10;
    settle();
    chk("t5_pop0", onehot, 8'h01);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("t5_hold_valid", out_valid, 1);
      chk("t5_hold_id", out_id, 0);
      chk("t5_hold_resp", out_resp, 1);
      chk("t5_hold_no_pop", onehot, 0);
      tick();
    end
    out_ready = 1'b1;
    settle();
    chk("t5_pop1", onehot, 8'h02);
    tick();
    settle();
    chk("t5_out1_valid", out_valid, 1);
    chk("t5_out1_id", out_id, 1);
    chk("t5_out1_resp", out_resp, 2);
    tick();
    settle();
    chk("t5_drained", out_valid, 0);
    idle_inputs();

    // Asynchronous reset while occupied
    do_reset();
    rsv_valid = 1'b1; rsv_id = 2'd0;
    for (int i = 0; i < 5; i++) tick();
    rsv_valid = 1'b0;
    in_valid = 1'b1; in_id = 2'd0; in_resp = 2'b11;
    release_en = 8'h01;
    tick();
    in_valid = 1'b0;
    tick();
    settle();
    chk("t6_pre_valid", out_valid, 1);
    chk("t6_pre_resp", out_resp, 3);
    chk("t6_pre_iid", rsv_iid, 0);
`ifdef SIMMEM_WRESP_BANK_STATS_EN
    chk("t6_pre_occupancy", occupancy, 5);
`endif
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_id", out_id, 0);
    chk("t6_rst_resp", out_resp, 0);
    chk("t6_rst_onehot", onehot, 0);
    chk("t6_rst_ready", rsv_ready, 1);
    chk("t6_rst_iid", rsv_iid, 0);
`ifdef SIMMEM_WRESP_BANK_STATS_EN
    chk("t6_rst_occupancy", occupancy, 0);
`endif
    idle_inputs();
    tick();
    rst = 1'b0;
    rsv_valid = 1'b1; rsv_id = 2'd2;
    settle();
    chk("t6_post_iid", rsv_iid, 0);
    tick();
    rsv_valid = 1'b0;
    settle();
    chk("t6_post_next_iid", rsv_iid, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
